// File: rtl/renas_dmem_arbiter_pkg.sv
// Shared types for the D-side memory arbiter: AHB command/response
// bundles and the arbiter state/error constants.
package AHB_package;

  typedef struct packed {
    logic [31:0] haddr;
    logic        hwrite;
    logic [31:0] hwdata;
    logic [2:0]  hsize;
  } mas_send_type;

  typedef struct packed {
    logic        hreadyout;
    logic        hresp;
    logic [31:0] hrdata;
  } slv_send_type;

endpackage

package renas_arb_package;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP,
    GAP
  } arb_state_e;

  localparam logic [31:0] ARB_ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/renas_dmem_arbiter_rr_pick.sv
// Two-requester round-robin picker; a tie goes to the port
// that did not win last.
module renas_rr_pick (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] win
);

  always_comb begin
    win = 2'b00;
    unique case (1'b1)
      (req == 2'b11): win = last_grant ? 2'b01 : 2'b10;
      (req == 2'b01): win = 2'b01;
      (req == 2'b10): win = 2'b10;
      default:        win = 2'b00;
    endcase
  end

endmodule

// File: rtl/renas_dmem_arbiter.sv
// CPU/DMA arbiter in front of the main-memory D-port, clk_l2 domain.
// Optional ACCESS watchdog: define RENAS_DMEM_ARB_TIMEOUT_EN.
module renas_dmem_arbiter
  import AHB_package::*;
  import renas_arb_package::*;
#(
  parameter int GAP_CYC     = 2,
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic         clk_l2,
  input  logic         rst_n,
  input  logic         m0_hsel,
  input  mas_send_type m0_in,
  output slv_send_type m0_out,
  input  logic         m1_hsel,
  input  mas_send_type m1_in,
  output slv_send_type m1_out,
  output logic         mem_hsel,
  output mas_send_type mem_out,
  input  slv_send_type mem_in,
  output logic [1:0]   grant,
  output logic         busy
);

  arb_state_e       state;
  logic             last_grant;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       win;
  logic             own_hsel;
  logic             done;
  slv_send_type     rsp;

  renas_rr_pick u_pick (
    .req        ({m1_hsel, m0_hsel}),
    .last_grant (last_grant),
    .win        (win)
  );

  assign own_hsel = grant[0] ? m0_hsel : m1_hsel;

  // An owner that dropped hsel mid-transfer gets no pulse.
  always_comb begin
    rsp           = '0;
    done          = mem_in.hreadyout;
    rsp.hreadyout = own_hsel;
    rsp.hresp     = mem_in.hresp;
    rsp.hrdata    = mem_in.hrdata;
`ifdef RENAS_DMEM_ARB_TIMEOUT_EN
    if (!mem_in.hreadyout &&
        cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
      done       = 1'b1;
      rsp.hresp  = 1'b1;
      rsp.hrdata = ARB_ERR_DATA;
    end
`endif
  end

  always_ff @(posedge clk_l2 or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      m0_out     <= '0;
      m1_out     <= '0;
      mem_hsel   <= 1'b0;
      mem_out    <= '0;
      grant      <= 2'b00;
      busy       <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (win != 2'b00) begin
            mem_out    <= win[0] ? m0_in : m1_in;
            grant      <= win;
            mem_hsel   <= 1'b1;
            last_grant <= win[1];
            busy       <= 1'b1;
            cnt        <= '0;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          if (done) begin
            if (grant[0]) m0_out <= rsp;
            else          m1_out <= rsp;
            mem_hsel <= 1'b0;
            state    <= RESP;
          end
`ifdef RENAS_DMEM_ARB_TIMEOUT_EN
          else begin
            cnt <= cnt + CNT_W'(1);
          end
`endif
        end
        RESP: begin
          m0_out.hreadyout <= 1'b0;
          m0_out.hresp     <= 1'b0;
          m1_out.hreadyout <= 1'b0;
          m1_out.hresp     <= 1'b0;
          grant            <= 2'b00;
          cnt              <= CNT_W'(GAP_CYC - 1);
          state            <= GAP;
        end
        GAP: begin
          if (cnt == '0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_renas_dmem_arbiter.sv
// Bench for renas_dmem_arbiter: vector table, per-port scoreboards
// and a small behavioural D-port memory.
module tb_renas_dmem_arbiter;
  import AHB_package::*;
  import renas_arb_package::*;

  localparam int GAP_CYC     = 2;
  localparam int TIMEOUT_CYC = 64;

  logic         clk_l2 = 1'b0;
  logic         rst_n  = 1'b0;
  logic         m0_hsel, m1_hsel, mem_hsel, busy;
  mas_send_type m0_in, m1_in, mem_out;
  slv_send_type m0_out, m1_out, mem_in;
  logic [1:0]   grant;

  always #5 clk_l2 = ~clk_l2;

  renas_dmem_arbiter #(
    .GAP_CYC     (GAP_CYC),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk_l2   (clk_l2),
    .rst_n    (rst_n),
    .m0_hsel  (m0_hsel),
    .m0_in    (m0_in),
    .m0_out   (m0_out),
    .m1_hsel  (m1_hsel),
    .m1_in    (m1_in),
    .m1_out   (m1_out),
    .mem_hsel (mem_hsel),
    .mem_out  (mem_out),
    .mem_in   (mem_in),
    .grant    (grant),
    .busy     (busy)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(logic [31:0] a);
    return 32'hA5A5_0000 | {22'b0, a[9:2], 2'b00};
  endfunction

  // Memory: answers one cycle after seeing mem_hsel, unless stuck.
  logic [31:0] mem [0:255];
  bit          stuck = 1'b0;
  int          wcnt;

  always @(posedge clk_l2 or negedge rst_n) begin
    if (!rst_n) begin
      mem_in <= '0;
      wcnt   <= 0;
      for (int i = 0; i < 256; i++)
        mem[i] <= 32'hA5A5_0000 | {22'b0, i[7:0], 2'b00};
    end else begin
      mem_in.hreadyout <= 1'b0;
      if (mem_hsel && !mem_in.hreadyout && !stuck) begin
        if (wcnt == 1) begin
          wcnt             <= 0;
          mem_in.hreadyout <= 1'b1;
          mem_in.hresp     <= 1'b0;
          if (mem_out.hwrite) begin
            mem[mem_out.haddr[9:2]] <= mem_out.hwdata;
            mem_in.hrdata           <= '0;
          end else begin
            mem_in.hrdata <= mem[mem_out.haddr[9:2]];
          end
        end else begin
          wcnt <= wcnt + 1;
        end
      end
    end
  end

  typedef struct packed {
    logic [31:0] d;
    logic        r;
  } exp_t;

  exp_t       sb0[$];
  exp_t       sb1[$];
  exp_t       e;
  logic [1:0] gtrace[$];
  logic [1:0] prev_grant = 2'b00;
  logic       prev_hsel  = 1'b0;
  bit         seen_fall  = 1'b0;
  int         low_cnt    = 0;
  int         pulses0    = 0;
  int         pulses1    = 0;

  always @(negedge clk_l2) begin
    if (rst_n) begin
      if (m0_out.hreadyout) begin
        pulses0++;
        chk("m0_pulse_owner", 64'(grant), 64'(2'b01));
        if (sb0.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL m0_unexpected_pulse: got 1 expected 0");
        end else begin
          e = sb0.pop_front();
          chk("m0_hrdata", 64'(m0_out.hrdata), 64'(e.d));
          chk("m0_hresp", 64'(m0_out.hresp), 64'(e.r));
        end
      end
      if (m1_out.hreadyout) begin
        pulses1++;
        chk("m1_pulse_owner", 64'(grant), 64'(2'b10));
        if (sb1.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL m1_unexpected_pulse: got 1 expected 0");
        end else begin
          e = sb1.pop_front();
          chk("m1_hrdata", 64'(m1_out.hrdata), 64'(e.d));
          chk("m1_hresp", 64'(m1_out.hresp), 64'(e.r));
        end
      end
      if (grant != prev_grant) begin
        gtrace.push_back(grant);
        prev_grant = grant;
      end
      if (mem_hsel) begin
        if (!prev_hsel && seen_fall)
          chk("gap_len_ok", 64'(low_cnt >= GAP_CYC + 1), 64'd1);
        low_cnt = 0;
      end else begin
        low_cnt++;
        if (prev_hsel) seen_fall = 1'b1;
      end
      prev_hsel = mem_hsel;
    end
  end

  task automatic clear_mon();
    sb0.delete();
    sb1.delete();
    gtrace.delete();
    prev_grant = 2'b00;
    prev_hsel  = 1'b0;
    seen_fall  = 1'b0;
    low_cnt    = 0;
  endtask

  task automatic issue(input int p, input logic [31:0] a,
                       input logic wr, input logic [31:0] wd,
                       input logic [31:0] ed, input logic er,
                       input bit lat);
    mas_send_type c;
    bit got;
    c = '0;
    c.haddr  = a;
    c.hwrite = wr;
    c.hwdata = wd;
    c.hsize  = 3'd2;
    if (p == 0) begin
      m0_in = c; m0_hsel = 1'b1; sb0.push_back({ed, er});
    end else begin
      m1_in = c; m1_hsel = 1'b1; sb1.push_back({ed, er});
    end
    if (lat) begin
      @(negedge clk_l2);
      chk("lat_mem_hsel", 64'(mem_hsel), 64'd1);
      chk("lat_grant", 64'(grant), (p == 0) ? 64'd1 : 64'd2);
      chk("lat_haddr", 64'(mem_out.haddr), 64'(a));
    end
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk_l2);
      got = (p == 0) ? m0_out.hreadyout : m1_out.hreadyout;
    end
    if (!got) begin
      n_chk++;
      n_fail++;
      $display("FAIL resp_timeout_p%0d: got no pulse expected pulse", p);
    end
    if (p == 0) m0_hsel = 1'b0;
    else        m1_hsel = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (!busy) ok = 1'b1;
      else @(negedge clk_l2);
    end
    if (!ok) begin
      n_chk++;
      n_fail++;
      $display("FAIL idle_timeout: got busy=1 expected 0");
    end
  endtask

  typedef struct {
    int          port;
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wd;
    logic [31:0] ed;
  } vec_t;

  vec_t       tbl[7];
  logic [1:0] nz[$];
  int         n0;

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{0, 32'h0000_2000, 1'b0, 32'h0, 32'hA5A5_0000};
    tbl[1] = '{1, 32'h0000_0010, 1'b1, 32'h1234_5678, 32'h0};
    tbl[2] = '{0, 32'h0000_0010, 1'b0, 32'h0, 32'h1234_5678};
    tbl[3] = '{1, 32'h0000_0010, 1'b0, 32'h0, 32'h1234_5678};
    tbl[4] = '{1, 32'h0000_0044, 1'b0, 32'h0, 32'hA5A5_0044};
    tbl[5] = '{0, 32'h0000_0044, 1'b1, 32'hCAFE_F00D, 32'h0};
    tbl[6] = '{1, 32'h0000_0044, 1'b0, 32'h0, 32'hCAFE_F00D};

    m0_hsel = 1'b0;
    m1_hsel = 1'b0;
    m0_in   = '0;
    m1_in   = '0;
    rst_n   = 1'b0;
    repeat (2) @(negedge clk_l2);
    chk("rst_mem_hsel", 64'(mem_hsel), 64'd0);
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_m0_out", 64'(m0_out), 64'd0);
    chk("rst_m1_out", 64'(m1_out), 64'd0);
    chk("rst_mem_out_zero", 64'(mem_out == '0), 64'd1);
    clear_mon();
    rst_n = 1'b1;
    @(negedge clk_l2);

    fork
      issue(0, 32'h100, 1'b0, 32'h0, exp_rd(32'h100), 1'b0, 1'b1);
      issue(1, 32'h104, 1'b0, 32'h0, exp_rd(32'h104), 1'b0, 1'b0);
    join
    wait_idle();
    while (gtrace.size() < 3) gtrace.push_back(2'b11);
    chk("tie_grant0", 64'(gtrace[0]), 64'(2'b01));
    chk("tie_grant1", 64'(gtrace[1]), 64'(2'b00));
    chk("tie_grant2", 64'(gtrace[2]), 64'(2'b10));

    for (int i = 0; i < 7; i++) begin
      wait_idle();
      issue(tbl[i].port, tbl[i].addr, tbl[i].wr, tbl[i].wd,
            tbl[i].ed, 1'b0, 1'b1);
    end
    wait_idle();

    // Owner abandons its request mid-transfer.
    n0      = pulses0;
    m0_in   = '0;
    m0_in.haddr = 32'h30;
    m0_hsel = 1'b1;
    @(negedge clk_l2);
    chk("drop_mem_hsel", 64'(mem_hsel), 64'd1);
    m0_hsel = 1'b0;
    repeat (2) @(negedge clk_l2);
    wait_idle();
    chk("drop_no_pulse", 64'(pulses0 - n0), 64'd0);
    issue(1, 32'h30, 1'b0, 32'h0, exp_rd(32'h30), 1'b0, 1'b1);
    wait_idle();

    rst_n = 1'b0;
    @(negedge clk_l2);
    clear_mon();
    rst_n = 1'b1;
    @(negedge clk_l2);
    fork
      for (int i = 0; i < 3; i++)
        issue(0, 32'h200 + 32'(i * 4), 1'b0, 32'h0,
              exp_rd(32'h200 + 32'(i * 4)), 1'b0, 1'b0);
      for (int i = 0; i < 3; i++)
        issue(1, 32'h280 + 32'(i * 4), 1'b0, 32'h0,
              exp_rd(32'h280 + 32'(i * 4)), 1'b0, 1'b0);
    join
    wait_idle();
    nz.delete();
    foreach (gtrace[i]) if (gtrace[i] != 2'b00) nz.push_back(gtrace[i]);
    chk("fair_count", 64'(nz.size()), 64'd6);
    while (nz.size() < 6) nz.push_back(2'b11);
    for (int i = 0; i < 6; i++)
      chk("fair_grant", 64'(nz[i]), (i % 2 == 0) ? 64'd1 : 64'd2);

`ifdef RENAS_DMEM_ARB_TIMEOUT_EN
    wait_idle();
    stuck = 1'b1;
    issue(0, 32'h300, 1'b0, 32'h0, ARB_ERR_DATA, 1'b1, 1'b1);
    stuck = 1'b0;
    wait_idle();
    chk("tmo_back_idle", 64'(busy), 64'd0);
`endif

    // Reset while a transfer is stuck in ACCESS.
    wait_idle();
    stuck   = 1'b1;
    m0_in   = '0;
    m0_in.haddr = 32'h400;
    m0_hsel = 1'b1;
    repeat (3) @(negedge clk_l2);
    chk("mid_access_hsel", 64'(mem_hsel), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_mem_hsel", 64'(mem_hsel), 64'd0);
    chk("arst_grant", 64'(grant), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_m0_out", 64'(m0_out), 64'd0);
    chk("arst_m1_out", 64'(m1_out), 64'd0);
    chk("arst_mem_out_zero", 64'(mem_out == '0), 64'd1);
    m0_hsel = 1'b0;
    stuck   = 1'b0;
    @(negedge clk_l2);
    clear_mon();
    rst_n = 1'b1;
    @(negedge clk_l2);
    fork
      issue(0, 32'h104, 1'b0, 32'h0, exp_rd(32'h104), 1'b0, 1'b1);
      issue(1, 32'h108, 1'b0, 32'h0, exp_rd(32'h108), 1'b0, 1'b0);
    join
    wait_idle();
    chk("sb0_drained", 64'(sb0.size()), 64'd0);
    chk("sb1_drained", 64'(sb1.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
